mem_tlb_op_ctrl: RTL and testbench

- Sequences TLBP/TLBR/TLBWI/TLBWR instructions while they occupy the MEM stage.
- Stalls the EXE->MEM pipeline register via the hazard unit.
- Arbitrates the single shared TLB port between the data-side translation path and the TLB instruction.
- Owns the CP0 Random counter and raises a refetch after TLB-modifying instructions.

---
 rtl/mem_tlb_op_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mem_tlb_op_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_tlb_op_ctrl.sv
// mem_tlb_op_ctrl
//   Sequences TLBP / TLBR / TLBWI / TLBWR while the instruction sits in MEM.
//   It holds the EXE->MEM register through the hazard unit and shares the
//   single TLB port with the data-side translation path. It also owns the
//   CP0 Random counter and requests a refetch after TLB-modifying ops.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   MEM_Valid, MEM_Is*        MEM stage instruction qualifiers
//   MEM_TLBWIorR              1 = TLBWI, 0 = TLBWR (with MEM_IsTLBW)
//   MEM_PC                    PC of the MEM instruction
//   Exc_Flush                 exception / eret flush
//   DTLB_Busy                 data-side lookup outstanding on the TLB port
//   CP0_Index, CP0_Wired      CP0 Index.index and Wired values
//   CP0_Wired_Wr              MTC0 to Wired this cycle
//   TLB_Stall                 hold EXE->MEM
//   DTLB_Hold                 data side must keep off the TLB port
//   TLB_Probe/Read/Write_En   single-cycle strobes to the TLB
//   TLB_Idx                   index for TLB read / write
//   CP0_Probe_Wr, CP0_Read_Wr latch the TLB result into CP0
//   Refetch_Req, Refetch_PC   fetch redirect after TLBR / TLBW
//   CP0_Random                current Random value
//   dbg_state                 FSM state (IDLE=0 WAIT=1 ISSUE=2 RESP=3 DONE=4)
//
// Handshake: a TLB op in MEM acts as "valid"; the stage is accepted (leaves
// MEM) only in a cycle where TLB_Stall is low. TLB_Stall drops exactly once
// per op, in DONE, so the instruction advances on that edge and the next
// IDLE cycle always sees a new instruction.
module mem_tlb_op_ctrl #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MEM_Valid,
    input  logic             MEM_IsTLBP,
    input  logic             MEM_IsTLBR,
    input  logic             MEM_IsTLBW,
    input  logic             MEM_TLBWIorR,
    input  logic [31:0]      MEM_PC,
    input  logic             Exc_Flush,
    input  logic             DTLB_Busy,
    input  logic [IDX_W-1:0] CP0_Index,
    input  logic [IDX_W-1:0] CP0_Wired,
    input  logic             CP0_Wired_Wr,
    output logic             TLB_Stall,
    output logic             DTLB_Hold,
    output logic             TLB_Probe_En,
    output logic             TLB_Read_En,
    output logic             TLB_Write_En,
    output logic [IDX_W-1:0] TLB_Idx,
    output logic             CP0_Probe_Wr,
    output logic             CP0_Read_Wr,
    output logic             Refetch_Req,
    output logic [31:0]      Refetch_PC,
    output logic [IDX_W-1:0] CP0_Random,
    output logic [2:0]       dbg_state
);

    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_RESP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state;
    logic             op;
    logic             start;
    logic             go_issue;
    logic             lat_p, lat_r, lat_w, lat_wi;
    logic             cur_p, cur_r, cur_w, cur_wi;
    logic [31:0]      pc_q;
    logic             flush_seen;
    logic [IDX_W-1:0] random_nxt;
    logic [IDX_W-1:0] idx_sel;

    assign op    = MEM_Valid & (MEM_IsTLBP | MEM_IsTLBR | MEM_IsTLBW);
    assign start = (state == S_IDLE) & op & ~Exc_Flush;

    // Enter ISSUE straight from IDLE or after WAIT, once the port is free.
    assign go_issue = (start | ((state == S_WAIT) & ~Exc_Flush)) & ~DTLB_Busy;

    // Only the IDLE-detect cycle stalls combinationally; after that the
    // stall is a pure decode of the state register.
    assign TLB_Stall = (state == S_IDLE) ? (start & ~rst) : (state != S_DONE);
    assign dbg_state = state;

    // Op type for the ISSUE set-up: live inputs when leaving IDLE directly,
    // latched copy when leaving WAIT.
    always_comb begin
        cur_p  = lat_p;
        cur_r  = lat_r;
        cur_w  = lat_w;
        cur_wi = lat_wi;
        if (state == S_IDLE) begin
            cur_p  = MEM_IsTLBP;
            cur_r  = MEM_IsTLBR;
            cur_w  = MEM_IsTLBW;
            cur_wi = MEM_TLBWIorR;
        end
    end

    // Random counts down from the top, wrapping at Wired. When Wired is at
    // or above the top the compare is always true, so Random parks at top.
    always_comb begin
        random_nxt = CP0_Random - IDX_W'(1);
        if (CP0_Wired_Wr || (CP0_Random <= CP0_Wired)) begin
            random_nxt = RAND_TOP;
        end
    end

    // TLB_Idx is registered on entry to ISSUE; for TLBWR it takes the Random
    // value that CP0_Random shows during that ISSUE cycle.
    assign idx_sel = (cur_w & ~cur_wi) ? random_nxt : CP0_Index;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            lat_p        <= 1'b0;
            lat_r        <= 1'b0;
            lat_w        <= 1'b0;
            lat_wi       <= 1'b0;
            pc_q         <= '0;
            flush_seen   <= 1'b0;
            DTLB_Hold    <= 1'b0;
            TLB_Probe_En <= 1'b0;
            TLB_Read_En  <= 1'b0;
            TLB_Write_En <= 1'b0;
            TLB_Idx      <= '0;
            CP0_Probe_Wr <= 1'b0;
            CP0_Read_Wr  <= 1'b0;
            Refetch_Req  <= 1'b0;
            Refetch_PC   <= '0;
            CP0_Random   <= RAND_TOP;
        end else begin
            CP0_Random   <= random_nxt;
            TLB_Probe_En <= 1'b0;
            TLB_Read_En  <= 1'b0;
            TLB_Write_En <= 1'b0;
            CP0_Probe_Wr <= 1'b0;
            CP0_Read_Wr  <= 1'b0;
            Refetch_Req  <= 1'b0;

            case (state)
                S_IDLE: begin
                    flush_seen <= 1'b0;
                    if (start) begin
                        lat_p  <= MEM_IsTLBP;
                        lat_r  <= MEM_IsTLBR;
                        lat_w  <= MEM_IsTLBW;
                        lat_wi <= MEM_TLBWIorR;
                        pc_q   <= MEM_PC;
                        state  <= DTLB_Busy ? S_WAIT : S_ISSUE;
                    end
                end
                S_WAIT: begin
                    // A flush here aborts before the TLB was touched.
                    if (Exc_Flush) begin
                        state <= S_IDLE;
                    end else if (!DTLB_Busy) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state        <= S_RESP;
                    CP0_Probe_Wr <= lat_p;
                    CP0_Read_Wr  <= lat_r;
                    if (Exc_Flush) begin
                        flush_seen <= 1'b1;
                    end
                end
                S_RESP: begin
                    // The TLB access is committed; a flush only cancels the
                    // redirect, since the flush itself already refetches.
                    state       <= S_DONE;
                    DTLB_Hold   <= 1'b0;
                    Refetch_Req <= (lat_r | lat_w) & ~flush_seen & ~Exc_Flush;
                    Refetch_PC  <= pc_q + 32'd4;
                    if (Exc_Flush) begin
                        flush_seen <= 1'b1;
                    end
                end
                S_DONE: begin
                    // MEM advances on this edge, so IDLE sees a new instruction.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (go_issue) begin
                DTLB_Hold    <= 1'b1;
                TLB_Probe_En <= cur_p;
                TLB_Read_En  <= cur_r;
                TLB_Write_En <= cur_w;
                TLB_Idx      <= idx_sel;
            end
        end
    end

endmodule

// File: tb/tb_mem_tlb_op_ctrl.sv
// tb_mem_tlb_op_ctrl
//   Directed and randomised TLB instruction sequences for mem_tlb_op_ctrl.
//   Expected TLB strobes, CP0 strobes and refetch targets are queued when an
//   op is driven and compared when the DUT produces them.
module tb_mem_tlb_op_ctrl;

    localparam int ENTRIES = 16;
    localparam int IW      = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          MEM_Valid, MEM_IsTLBP, MEM_IsTLBR, MEM_IsTLBW, MEM_TLBWIorR;
    logic [31:0]   MEM_PC;
    logic          Exc_Flush, DTLB_Busy;
    logic [IW-1:0] CP0_Index, CP0_Wired;
    logic          CP0_Wired_Wr;
    logic          TLB_Stall, DTLB_Hold, TLB_Probe_En, TLB_Read_En, TLB_Write_En;
    logic [IW-1:0] TLB_Idx;
    logic          CP0_Probe_Wr, CP0_Read_Wr, Refetch_Req;
    logic [31:0]   Refetch_PC;
    logic [IW-1:0] CP0_Random;
    logic [2:0]    dbg_state;

    mem_tlb_op_ctrl #(.TLB_ENTRIES(ENTRIES), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst),
        .MEM_Valid(MEM_Valid), .MEM_IsTLBP(MEM_IsTLBP), .MEM_IsTLBR(MEM_IsTLBR),
        .MEM_IsTLBW(MEM_IsTLBW), .MEM_TLBWIorR(MEM_TLBWIorR), .MEM_PC(MEM_PC),
        .Exc_Flush(Exc_Flush), .DTLB_Busy(DTLB_Busy),
        .CP0_Index(CP0_Index), .CP0_Wired(CP0_Wired), .CP0_Wired_Wr(CP0_Wired_Wr),
        .TLB_Stall(TLB_Stall), .DTLB_Hold(DTLB_Hold),
        .TLB_Probe_En(TLB_Probe_En), .TLB_Read_En(TLB_Read_En), .TLB_Write_En(TLB_Write_En),
        .TLB_Idx(TLB_Idx), .CP0_Probe_Wr(CP0_Probe_Wr), .CP0_Read_Wr(CP0_Read_Wr),
        .Refetch_Req(Refetch_Req), .Refetch_PC(Refetch_PC), .CP0_Random(CP0_Random),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [6:0]  exp_iss_q[$];   // {probe, read, write, idx}
    logic [1:0]  exp_cp0_q[$];   // {probe_wr, read_wr}
    logic [31:0] exp_ref_q[$];   // refetch target
    logic [6:0]  mon_iss;
    logic [1:0]  mon_cp0;
    logic [IW-1:0] model_rand;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] rand_step(input logic [IW-1:0] cur,
                                                input logic [IW-1:0] wired,
                                                input logic wr);
        if (wr || cur <= wired) return 4'd15;
        return cur - 4'd1;
    endfunction

    // Reference Random counter, used to predict the TLBWR index.
    always @(posedge clk or posedge rst) begin
        if (rst) model_rand <= 4'd15;
        else     model_rand <= rand_step(model_rand, CP0_Wired, CP0_Wired_Wr);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (TLB_Probe_En | TLB_Read_En | TLB_Write_En) begin
                mon_iss = {TLB_Probe_En, TLB_Read_En, TLB_Write_En,
                           (TLB_Read_En | TLB_Write_En) ? TLB_Idx : 4'd0};
                check_eq("issue_hold", 32'(DTLB_Hold), 32'd1);
                check_eq("issue_stall", 32'(TLB_Stall), 32'd1);
                if (exp_iss_q.size() > 0) check_eq("issue", 32'(mon_iss), 32'(exp_iss_q.pop_front()));
                else                      check_eq("issue_unexpected", 32'(mon_iss), 32'd0);
            end
            if (CP0_Probe_Wr | CP0_Read_Wr) begin
                mon_cp0 = {CP0_Probe_Wr, CP0_Read_Wr};
                if (exp_cp0_q.size() > 0) check_eq("cp0_strobe", 32'(mon_cp0), 32'(exp_cp0_q.pop_front()));
                else                      check_eq("cp0_unexpected", 32'(mon_cp0), 32'd0);
            end
            if (Refetch_Req) begin
                if (exp_ref_q.size() > 0) check_eq("refetch_pc", Refetch_PC, exp_ref_q.pop_front());
                else                      check_eq("refetch_unexpected", Refetch_PC, 32'hDEAD_BEEF);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic reset_checks(input string tag);
        check_eq({tag, "_stall"},  32'(TLB_Stall),    32'd0);
        check_eq({tag, "_hold"},   32'(DTLB_Hold),    32'd0);
        check_eq({tag, "_strobe"}, 32'({TLB_Probe_En, TLB_Read_En, TLB_Write_En}), 32'd0);
        check_eq({tag, "_cp0"},    32'({CP0_Probe_Wr, CP0_Read_Wr}), 32'd0);
        check_eq({tag, "_ref"},    32'(Refetch_Req),  32'd0);
        check_eq({tag, "_idx"},    32'(TLB_Idx),      32'd0);
        check_eq({tag, "_refpc"},  Refetch_PC,        32'd0);
        check_eq({tag, "_random"}, 32'(CP0_Random),   32'd15);
        check_eq({tag, "_state"},  32'(dbg_state),    32'd0);
    endtask

    // kind: 0 TLBP, 1 TLBR, 2 TLBWI, 3 TLBWR. busy: DTLB_Busy cycles from the
    // first MEM cycle. flush_cyc: cycle of a one-cycle Exc_Flush (-1 = none).
    // Entered and left one time unit after a rising edge.
    task automatic run_op(input int kind, input logic [31:0] pc, input logic [3:0] idx,
                          input int busy, input int flush_cyc);
        int cyc = 0, stall_n = 0, iss_at = -1, cp0_at = -1, ref_at = -1;
        int post, exp_stall;
        bit done = 0, adv, aborted, supp;
        logic [3:0] r;
        aborted = (flush_cyc >= 0) && (flush_cyc <= busy);
        supp    = (flush_cyc > busy);
        post    = (flush_cyc >= 0) ? 3 : 0;
        if (aborted)                               exp_stall = flush_cyc + 1;
        else if (flush_cyc >= 0 && flush_cyc < busy + 3) exp_stall = flush_cyc + 1;
        else                                       exp_stall = busy + 3;
        r = model_rand;
        for (int i = 0; i <= busy; i++) r = rand_step(r, CP0_Wired, 1'b0);
        if (!aborted) begin
            exp_iss_q.push_back({kind == 0, kind == 1, kind >= 2,
                                 (kind == 0) ? 4'd0 : ((kind == 3) ? r : idx)});
            if (kind <= 1) exp_cp0_q.push_back({kind == 0, kind == 1});
            if (kind >= 1 && !supp) exp_ref_q.push_back(pc + 32'd4);
        end
        MEM_Valid    = 1'b1;
        MEM_IsTLBP   = (kind == 0);
        MEM_IsTLBR   = (kind == 1);
        MEM_IsTLBW   = (kind >= 2);
        MEM_TLBWIorR = (kind == 2);
        MEM_PC       = pc;
        CP0_Index    = idx;
        while (cyc < 40 && (!done || post > 0)) begin
            if (done) post--;
            DTLB_Busy = !done && (cyc < busy);
            Exc_Flush = !done && (cyc == flush_cyc);
            @(negedge clk);
            if (!done && TLB_Stall) stall_n++;
            if (TLB_Probe_En | TLB_Read_En | TLB_Write_En) iss_at = cyc;
            if (CP0_Probe_Wr | CP0_Read_Wr) cp0_at = cyc;
            if (Refetch_Req) ref_at = cyc;
            if (!done && cyc >= 1 && cyc <= busy)
                check_eq("wait_quiet", 32'({DTLB_Hold, TLB_Probe_En, TLB_Read_En, TLB_Write_En}), 32'd0);
            adv = !TLB_Stall || Exc_Flush;
            @(posedge clk);
            #1;
            if (!done && adv) begin
                done = 1;
                MEM_Valid = 1'b0; MEM_IsTLBP = 1'b0; MEM_IsTLBR = 1'b0; MEM_IsTLBW = 1'b0;
            end
            cyc++;
        end
        DTLB_Busy = 1'b0;
        Exc_Flush = 1'b0;
        check_eq("op_done", 32'(done), 32'd1);
        check_eq("stall_cycles", 32'(stall_n), 32'(exp_stall));
        check_eq("issue_cycle", 32'(iss_at), aborted ? 32'hFFFF_FFFF : 32'(busy + 1));
        check_eq("cp0_cycle", 32'(cp0_at), (!aborted && kind <= 1) ? 32'(busy + 2) : 32'hFFFF_FFFF);
        check_eq("refetch_cycle", 32'(ref_at),
                 (!aborted && kind >= 1 && !supp) ? 32'(busy + 3) : 32'hFFFF_FFFF);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        MEM_Valid = 1'b0; MEM_IsTLBP = 1'b0; MEM_IsTLBR = 1'b0; MEM_IsTLBW = 1'b0;
        MEM_TLBWIorR = 1'b0; MEM_PC = '0; Exc_Flush = 1'b0; DTLB_Busy = 1'b0;
        CP0_Index = '0; CP0_Wired = '0; CP0_Wired_Wr = 1'b0;
        @(negedge clk);
        reset_checks("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        run_op(0, 32'h8000_0200, 4'd7, 0, -1);            // TLBP
        run_op(2, 32'h8000_1000, 4'd5, 0, -1);            // TLBWI
        run_op(1, 32'h8000_2000, 4'd9, 3, -1);            // TLBR, 3 WAIT cycles

        // Random sequence with Wired = 2, starting from a Wired write.
        CP0_Wired = 4'd2; CP0_Wired_Wr = 1'b1;
        @(posedge clk);
        #1 CP0_Wired_Wr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_eq("random_seq", 32'(CP0_Random), (i <= 13) ? 32'(15 - i) : 32'(29 - i));
        end
        @(posedge clk);
        #1 CP0_Wired = 4'd15;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("random_park", 32'(CP0_Random), 32'd15);
        end
        @(posedge clk);
        #1 CP0_Wired = 4'd2;

        run_op(3, 32'h8000_3000, 4'd1, 0, -1);            // TLBWR
        run_op(3, 32'h8000_3100, 4'd1, 2, -1);            // TLBWR after WAIT
        run_op(1, 32'h8000_4000, 4'd4, 3, 2);             // flush in WAIT
        run_op(1, 32'h8000_5000, 4'd6, 0, 2);             // flush in RESP
        run_op(2, 32'hFFFF_FFFC, 4'd2, 0, -1);            // PC wrap

        for (int n = 0; n < 8; n++) begin                 // back-to-back mix
            run_op(int'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC,
                   4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), -1);
        end

        // Asynchronous reset in the middle of RESP.
        MEM_Valid = 1'b1; MEM_IsTLBR = 1'b1; MEM_PC = 32'h8000_6000; CP0_Index = 4'd3;
        exp_iss_q.push_back({3'b010, 4'd3});
        @(posedge clk);
        #1;
        @(posedge clk);
        #2 rst = 1'b1;
        MEM_Valid = 1'b0; MEM_IsTLBR = 1'b0;
        #1 reset_checks("midresp_reset");
        @(posedge clk);
        #1 rst = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check_eq("issue_q_left", 32'(exp_iss_q.size()), 32'd0);
        check_eq("cp0_q_left", 32'(exp_cp0_q.size()), 32'd0);
        check_eq("ref_q_left", 32'(exp_ref_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
